// File: rtl/cpu_boot_loader.sv
// Byte-serial program loader: assembles big-endian words into instruction memory and holds the CPU until done.
// Optional trailing checksum word enabled by defining BOOT_CHECKSUM_EN.
module cpu_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [7:0]            RxData,
  input  logic                  RxValid,
  output logic                  RxReady,
  output logic [ADDR_WIDTH-1:0] ImemAddr,
  output logic [15:0]           ImemData,
  output logic                  ImemWrite,
  output logic                  CpuHold,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [3:0] {
    HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO, FLUSH, RUN, ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [16:0]           MAX_WORDS = 17'(2 ** ADDR_WIDTH);
`ifdef BOOT_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHK_HI;
`else
  localparam state_t AFTER_DATA = FLUSH;
`endif

  state_t                  state_q, state_d;
  logic [7:0]              hi_q, hi_d;
  logic [15:0]             n_q, n_d;
  logic [15:0]             idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             data_q, data_d;
  logic                    wr_q, wr_d;
  logic                    done_q, hold_q;
`ifdef BOOT_CHECKSUM_EN
  logic [15:0]             sum_q, sum_d;
`endif

  logic        rx_ready;
  logic        accept;
  logic [15:0] word;

  always_comb begin
    rx_ready = (state_q == HDR_HI) || (state_q == HDR_LO) ||
               (state_q == DAT_HI) || (state_q == DAT_LO) ||
               (state_q == CHK_HI) || (state_q == CHK_LO);
    accept   = rx_ready && RxValid;
    word     = {hi_q, RxData};
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    n_d     = n_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      HDR_HI: if (accept) begin
        hi_d    = RxData;
        state_d = HDR_LO;
      end
      HDR_LO: if (accept) begin
        n_d   = word;
        idx_d = '0;
        if ({1'b0, word} > MAX_WORDS)  state_d = ERROR;
        else if (word == 16'd0)        state_d = AFTER_DATA;
        else                           state_d = DAT_HI;
      end
      DAT_HI: if (accept) begin
        hi_d    = RxData;
        state_d = DAT_LO;
      end
      DAT_LO: if (accept) begin
        data_d = word;
        addr_d = BASE_A + idx_q[ADDR_WIDTH-1:0];
        wr_d   = 1'b1;
        idx_d  = idx_q + 16'd1;
`ifdef BOOT_CHECKSUM_EN
        sum_d  = sum_q + word;
`endif
        // idx_q < n_q always holds here, so the increment cannot overflow
        state_d = (idx_q + 16'd1 == n_q) ? AFTER_DATA : DAT_HI;
      end
`ifdef BOOT_CHECKSUM_EN
      CHK_HI: if (accept) begin
        hi_d    = RxData;
        state_d = CHK_LO;
      end
      CHK_LO: if (accept) begin
        state_d = (word == sum_q) ? FLUSH : ERROR;
      end
`endif
      FLUSH:   state_d = RUN;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= HDR_HI;
      hi_q    <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      addr_q  <= BASE_A;
      data_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      hold_q  <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      // Release is registered off RUN so the CPU starts one cycle after FLUSH ends
      done_q  <= (state_q == RUN);
      hold_q  <= (state_q != RUN);
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign RxReady   = rx_ready && !Reset;
  assign ImemAddr  = addr_q;
  assign ImemData  = data_q;
  assign ImemWrite = wr_q;
  assign CpuHold   = hold_q;
  assign Done      = done_q;
  assign Error     = (state_q == ERROR);

endmodule
